// File: rtl/sort_pkg.sv
// Shared constants and types for the 16-lane sorting network and its scheduler.
package sort_pkg;

   localparam int unsigned SORT_LANES    = 16;
   localparam int unsigned SORT_DATA_W   = 32;
   localparam int unsigned SORT_BLOCK_W  = SORT_LANES * SORT_DATA_W;
   localparam int unsigned SORT_LATENCY  = 11;
   // Tag ID is sized for the largest supported requester count (8).
   localparam int unsigned SORT_ID_MAX_W = 3;

   typedef logic [SORT_BLOCK_W-1:0] sort_block_t;

   typedef struct packed {
      logic                     vld;
      logic [SORT_ID_MAX_W-1:0] id;
   } sort_tag_t;

endpackage

// File: rtl/sort_net_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the rotating pointer, which moves past
// the winner only when the arbiter is enabled and something is requesting.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 en,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int unsigned IDX_W = $clog2(N);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int unsigned off = 0; off < N; off++) begin
         cand = IDX_W'((32'(ptr) + off) % N);
         if (en && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (en && |req) begin
         ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/sort_net_scheduler.sv
// Shares one pipelined sorting network between NUM_REQ requesters, tracking IDs
// through the network latency. Optional perf counters: SORT_SCHED_PERF_EN.
module sort_net_scheduler
   import sort_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned LATENCY = SORT_LATENCY,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*512-1:0]    req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      net_ena,
   output logic [511:0]              net_data_in,
   input  logic [511:0]              net_data_out,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [511:0]              rsp_data,
   input  logic                      rsp_ready,
   output logic                      busy
`ifdef SORT_SCHED_PERF_EN
   ,
   output logic [31:0]               perf_issued,
   output logic [31:0]               perf_stall
`endif
);

   sort_tag_t          tag [LATENCY];
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               arb_en;

   assign rsp_valid = tag[LATENCY-1].vld;
   assign rsp_id    = tag[LATENCY-1].id[ID_W-1:0];
   assign rsp_data  = net_data_out;
   assign net_ena   = !(rsp_valid && !rsp_ready);
   // Keep grants off while reset is held so req_ready/net_data_in read idle.
   assign arb_en    = net_ena && rst_n;

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready   = gnt;
   assign net_data_in = (|gnt) ? req_data[32'(gnt_idx)*SORT_BLOCK_W +: SORT_BLOCK_W] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < LATENCY; k++) tag[k] <= '0;
      end else if (net_ena) begin
         tag[0].vld <= |gnt;
         tag[0].id  <= SORT_ID_MAX_W'(gnt_idx);
         for (int unsigned k = 1; k < LATENCY; k++) tag[k] <= tag[k-1];
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int unsigned k = 0; k < LATENCY; k++) busy = busy | tag[k].vld;
   end

`ifdef SORT_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (|gnt && perf_issued != '1) perf_issued <= perf_issued + 1'b1;
         if (!net_ena && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sort_net_scheduler.sv
// Self-checking bench for sort_net_scheduler with a behavioural sorting network
// and a queue-based scoreboard of in-flight blocks.
module tb_sort_net_scheduler;
   import sort_pkg::*;

   localparam int unsigned NREQ = 4;
   localparam int unsigned LAT  = 11;
   localparam int unsigned IDW  = 2;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b1;
   logic [NREQ-1:0]        req_valid = '0;
   logic [NREQ*512-1:0]    req_data = '0;
   logic [NREQ-1:0]        req_ready;
   logic                   net_ena;
   logic [511:0]           net_data_in;
   logic [511:0]           net_data_out;
   logic                   rsp_valid;
   logic [IDW-1:0]         rsp_id;
   logic [511:0]           rsp_data;
   logic                   rsp_ready = 1'b1;
   logic                   busy;
`ifdef SORT_SCHED_PERF_EN
   logic [31:0]            perf_issued;
   logic [31:0]            perf_stall;
`endif

   always #5 clk = ~clk;

   sort_net_scheduler #(
      .NUM_REQ(NREQ),
      .LATENCY(LAT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .net_ena      (net_ena),
      .net_data_in  (net_data_in),
      .net_data_out (net_data_out),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_data     (rsp_data),
      .rsp_ready    (rsp_ready),
      .busy         (busy)
`ifdef SORT_SCHED_PERF_EN
      ,
      .perf_issued  (perf_issued),
      .perf_stall   (perf_stall)
`endif
   );

   function automatic logic [511:0] sort_block(input logic [511:0] b);
      logic [31:0]  v [16];
      logic [31:0]  t;
      logic [511:0] r;
      for (int i = 0; i < 16; i++) v[i] = b[i*32 +: 32];
      for (int i = 0; i < 15; i++)
         for (int j = 0; j < 15 - i; j++)
            if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = v[i];
      return r;
   endfunction

   // Network stand-in: LAT enabled registers, sorted on entry, never reset.
   logic [511:0] net_pipe [LAT];
   assign net_data_out = net_pipe[LAT-1];
   always @(posedge clk) begin
      if (net_ena) begin
         for (int k = LAT - 1; k > 0; k--) net_pipe[k] <= net_pipe[k-1];
         net_pipe[0] <= sort_block(net_data_in);
      end
   end

   typedef struct {
      int           id;
      logic [511:0] data;
      int           age;
   } item_t;

   typedef struct {
      logic [NREQ-1:0] rv;
      logic [NREQ-1:0] gnt;
   } arb_vec_t;

   item_t        q[$];
   int           mptr = 0;
   int           vec_cnt = 0;
   int           err_cnt = 0;
   logic         s_rsp_valid, s_net_ena, s_busy;
   logic [NREQ-1:0] s_req_ready;
   logic [IDW-1:0]  s_rsp_id;
   logic [511:0]    s_rsp_data;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NREQ*512-1:0] rand_blocks();
      logic [NREQ*512-1:0] r;
      for (int i = 0; i < NREQ * 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock cycle: drive at negedge, compare against the model, advance the model at posedge.
   task automatic step(input logic [NREQ-1:0] rv, input logic rr, input logic [NREQ*512-1:0] rd);
      logic         exp_v, exp_ena;
      logic [NREQ-1:0] exp_gnt;
      logic [511:0] exp_din;
      int           gi;
      @(negedge clk);
      req_valid = rv;
      rsp_ready = rr;
      req_data  = rd;
      #1;
      exp_v   = (q.size() > 0) && (q[0].age == LAT - 1);
      exp_ena = !(exp_v && !rr);
      exp_gnt = '0;
      exp_din = '0;
      gi      = -1;
      if (exp_ena)
         for (int off = 0; off < NREQ; off++)
            if (gi < 0 && rv[(mptr + off) % NREQ]) gi = (mptr + off) % NREQ;
      if (gi >= 0) begin
         exp_gnt[gi] = 1'b1;
         exp_din     = rd[gi*512 +: 512];
      end
      chk("req_ready", 512'(req_ready), 512'(exp_gnt));
      chk("net_ena", 512'(net_ena), 512'(exp_ena));
      chk("net_data_in", net_data_in, exp_din);
      chk("rsp_valid", 512'(rsp_valid), 512'(exp_v));
      chk("busy", 512'(busy), 512'(q.size() > 0));
      if (exp_v && rsp_valid) begin
         chk("rsp_id", 512'(rsp_id), 512'(q[0].id));
         chk("rsp_data", rsp_data, q[0].data);
      end
      s_rsp_valid = rsp_valid; s_net_ena = net_ena; s_busy = busy;
      s_req_ready = req_ready; s_rsp_id = rsp_id; s_rsp_data = rsp_data;
      @(posedge clk);
      if (exp_ena) begin
         if (exp_v) void'(q.pop_front());
         foreach (q[k]) q[k].age++;
         if (gi >= 0) begin
            q.push_back('{id: gi, data: sort_block(exp_din), age: 0});
            mptr = (gi + 1) % NREQ;
         end
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      q.delete();
      mptr = 0;
      #1;
      chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
      chk("rst_rsp_id", 512'(rsp_id), 512'(0));
      chk("rst_busy", 512'(busy), 512'(0));
      chk("rst_req_ready", 512'(req_ready), 512'(0));
      chk("rst_net_ena", 512'(net_ena), 512'(1));
      chk("rst_net_data_in", net_data_in, 512'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int guard = 0;
      while (q.size() > 0 && guard < 4 * LAT) begin
         step('0, 1'b1, rand_blocks());
         guard++;
      end
      chk("drain_empty", 512'(q.size()), 512'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arb_vec_t            tbl [16];
      logic [NREQ*512-1:0] rd;
      logic [511:0]        asc, held;
      int                  stalls, vcount;

      tbl = '{
         '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
         '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
         '{4'b1010, 4'b0010}, '{4'b1010, 4'b1000}, '{4'b0001, 4'b0001}, '{4'b0000, 4'b0000},
         '{4'b0001, 4'b0001}, '{4'b0110, 4'b0010}, '{4'b1100, 4'b0100}, '{4'b0111, 4'b0001}};

      #1;
      do_reset();

      // Single block from requester 2, lanes 15..0.
      rd = rand_blocks();
      for (int i = 0; i < 16; i++) begin
         rd[2*512 + i*32 +: 32] = 32'(15 - i);
         asc[i*32 +: 32]        = 32'(i);
      end
      step(4'b0100, 1'b1, rd);
      for (int j = 1; j <= LAT + 1; j++) begin
         step('0, 1'b1, rand_blocks());
         if (j == LAT - 1) chk("single_early", 512'(s_rsp_valid), 512'(0));
         if (j == LAT) begin
            chk("single_valid", 512'(s_rsp_valid), 512'(1));
            chk("single_id", 512'(s_rsp_id), 512'(2));
            chk("single_data", s_rsp_data, asc);
         end
         if (j == LAT + 1) begin
            chk("single_once", 512'(s_rsp_valid), 512'(0));
            chk("single_busy_fall", 512'(s_busy), 512'(0));
         end
      end

      // Arbitration table, including full contention.
      do_reset();
      for (int r = 0; r < 16; r++) begin
         step(tbl[r].rv, 1'b1, rand_blocks());
         chk("tbl_gnt", 512'(s_req_ready), 512'(tbl[r].gnt));
      end
      drain();

      // Back-pressure with three blocks in flight.
      do_reset();
      step(4'b0001, 1'b1, rand_blocks());
      step(4'b0010, 1'b1, rand_blocks());
      step(4'b1000, 1'b1, rand_blocks());
      for (int j = 3; j < LAT; j++) step('0, 1'b1, rand_blocks());
      stalls = 0;
      for (int j = 0; j < 5; j++) begin
         step(4'b1111, 1'b0, rand_blocks());
         if (j == 0) held = s_rsp_data;
         if (!s_net_ena) stalls++;
         chk("bp_no_ready", 512'(s_req_ready), 512'(0));
         chk("bp_hold", s_rsp_data, held);
      end
      chk("bp_stall_cycles", 512'(stalls), 512'(5));
      for (int j = 0; j < 4; j++) begin
         step('0, 1'b1, rand_blocks());
         chk("bp_deliver", 512'(s_rsp_valid), 512'(j < 3));
         if (j == 0) chk("bp_id0", 512'(s_rsp_id), 512'(0));
         if (j == 1) chk("bp_id1", 512'(s_rsp_id), 512'(1));
         if (j == 2) chk("bp_id2", 512'(s_rsp_id), 512'(3));
      end
`ifdef SORT_SCHED_PERF_EN
      chk("perf_issued", 512'(perf_issued), 512'(3));
      chk("perf_stall", 512'(perf_stall), 512'(5));
`endif

      // Sparse issue: every other cycle.
      do_reset();
      for (int j = 0; j < LAT + 8; j++) begin
         step((j < 8 && j % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, rand_blocks());
         if (j >= LAT && j < LAT + 8)
            chk("sparse_pattern", 512'(s_rsp_valid), 512'((j - LAT) % 2 == 0));
      end
      drain();

      // Reset with six blocks in flight.
      do_reset();
      for (int j = 0; j < 6; j++) step(4'b1111, 1'b1, rand_blocks());
      for (int j = 6; j < LAT; j++) step('0, 1'b1, rand_blocks());
      step('0, 1'b0, rand_blocks());
      #2;
      chk("pre_rst_valid", 512'(rsp_valid), 512'(1));
      chk("pre_rst_busy", 512'(busy), 512'(1));
      do_reset();
      vcount = 0;
      for (int j = 0; j < 2 * LAT; j++) begin
         step('0, 1'b1, rand_blocks());
         if (s_rsp_valid) vcount++;
      end
      chk("no_stale_rsp", 512'(vcount), 512'(0));

      // Randomized traffic against the scoreboard.
      do_reset();
      for (int j = 0; j < 400; j++)
         step(NREQ'($urandom), ($urandom_range(0, 3) != 0), rand_blocks());
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/sort_net_scheduler.md
# sort_net_scheduler

Shares the 16-lane, 32-bit pipelined sorting network between `NUM_REQ` requesters. Each cycle it round-robin arbitrates one 512-bit block into the network and tags it with the requester ID. It tracks tags through the fixed network latency and returns each sorted block with its ID on a valid/ready response port. It owns the network's `ena` input and stalls the whole pipeline when the response port is back-pressured.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `LATENCY`, 11: enabled clock edges from `net_data_in` capture to the result on `net_data_out`.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID; derived, not overridden.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NUM_REQ`: per-requester block valid.
- `req_data`, in, `NUM_REQ*512`: per-requester block; requester i occupies bits `[i*512 +: 512]`.
- `req_ready`, out, `NUM_REQ`: one-hot grant; a transfer happens when `req_valid[i] && req_ready[i]`.
- `net_ena`, out, 1: drives the sorting network's `ena`.
- `net_data_in`, out, 512: drives the sorting network's `data_in`.
- `net_data_out`, in, 512: the sorting network's registered `data_out`.
- `rsp_valid`, out, 1: sorted block available.
- `rsp_id`, out, `ID_W`: requester that issued the block.
- `rsp_data`, out, 512: sorted block; a direct pass-through of `net_data_out`.
- `rsp_ready`, in, 1: consumer accepts the response.
- `busy`, out, 1: at least one block is in flight or being held on the response port.

## Operation
- **Tag pipeline.** `LATENCY` entries of `{vld, id}`. It shifts only when `net_ena` = 1, so it stays aligned with the network registers.
- **Stall rule.** `net_ena = !(rsp_valid && !rsp_ready)`. This is combinational from `rsp_ready`. While stalled:
  - `req_ready` = 0;
  - the tag pipeline and the arbiter pointer hold.
- **Arbitration** (only when `net_ena` = 1):
  - Search `req_valid` starting at `ptr`, wrapping modulo `NUM_REQ`. The first set bit i wins.
  - `req_ready[i]` = 1 and `net_data_in = req_data[i]`.
  - `tag[0] <= {1, i}` and `ptr <= (i+1) mod NUM_REQ`.
- **No request** while `net_ena` = 1:
  - bubble `tag[0] <= {0, 0}`;
  - `net_data_in` = 0;
  - `ptr` holds.
- **Response outputs.**
  - `rsp_valid = tag[LATENCY-1].vld`
  - `rsp_id = tag[LATENCY-1].id`
  - `rsp_data = net_data_out`
- **Busy.** `busy` = OR of all `tag[*].vld`.
- **Ordering.** Responses leave in issue order. Nothing is dropped or duplicated. The network has no flush, so a bubble slot's `net_data_out` is ignored.
- **Reset.**
  - Outputs: `rsp_valid` = 0, `rsp_id` = 0, `busy` = 0, `req_ready` = 0, `net_ena` = 1, `net_data_in` = 0.
  - State: all tags invalid, `ptr` = 0.
  - Mid-operation reset discards every in-flight block; stale network contents are never flagged valid.

## Timing
- **Latency.** A block accepted at edge E with no stalls gives `rsp_valid` = 1 in the cycle following edge E+LATENCY-1, i.e. LATENCY cycles after acceptance.
- **Stalls.** Each cycle with `net_ena` = 0 adds exactly one cycle to the latency of every in-flight block.
- **Throughput.** One block per cycle when `rsp_ready` is held at 1.
- **Simultaneous accept and return.** Allowed in the same cycle; the pipeline is fully overlapped.
- **Holding a response.** `rsp_valid`, `rsp_id` and `rsp_data` stay stable while `rsp_valid && !rsp_ready`.
- **Fairness.** Under continuous contention, every requester is granted at least once every `NUM_REQ` issue cycles.

## Configuration
- Macro: `SORT_SCHED_PERF_EN`.
- **Defined:** adds two outputs, both reset to 0 and both saturating at `32'hFFFF_FFFF`:
  - `perf_issued` [31:0]: increments on each accepted request;
  - `perf_stall` [31:0]: increments on each cycle with `net_ena` = 0.
- **Undefined:** neither port nor its counter exists. All other behaviour is identical.

## Structure
- **Package `sort_pkg`:**
  - `SORT_LANES` = 16, `SORT_DATA_W` = 32, `SORT_BLOCK_W` = 512, `SORT_LATENCY` = 11;
  - typedef `sort_block_t` (logic [511:0]);
  - typedef `sort_tag_t` (`vld` + id).
- **Sub-module `rr_arbiter`** (parameter N):
  - Inputs: `req` [N], `en`.
  - Outputs: one-hot `gnt` [N] and the encoded `gnt_idx`.
  - The rotating pointer lives inside `rr_arbiter` and advances only on `en && |req`.
- The top level holds the tag shift register, the stall logic and the optional perf counters.

## Test plan
1. **Single block, no contention.** Requester 2 sends lanes 15..0, `rsp_ready` = 1 → exactly LATENCY cycles later, `rsp_valid` = 1 for one cycle, `rsp_id` = 2, `rsp_data` = network result (ascending); `busy` falls the next cycle.
2. **Full contention.** `NUM_REQ` = 4, all `req_valid` held for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses arrive back-to-back with the same ID order.
3. **Back-pressure.** Drop `rsp_ready` for 5 cycles while 3 blocks are in flight → `net_ena` = 0 for 5 cycles; response held stable; no `req_ready`; all 3 blocks are delivered afterwards with no loss; latency of each = LATENCY + 5.
4. **Sparse issue.** Issue in alternating cycles → `rsp_valid` alternates with the same spacing; bubbles are never flagged valid.
5. **Reset mid-operation.** Assert `rst_n` = 0 with 6 blocks in flight → `rsp_valid` and `busy` go low immediately (asynchronously); after release, no stale response appears within 2×LATENCY cycles.
6. **Perf counters** (`SORT_SCHED_PERF_EN` defined). Scenario 3 → `perf_issued` = 3, `perf_stall` = 5.
